// File: rtl/pcpi_hub_pkg.sv
// Shared types and constants for the PCPI coprocessor hub.
// State encoding is fixed so debug tooling can decode dbg_state directly.
package pcpi_hub_pkg;

    localparam int DATA_W  = 32;
    localparam int OWNER_W = 3;
    localparam int MAX_COP = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLAIM = 3'd1,
        ST_BUSY  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // True when more than one bit of the request vector is set.
    function automatic logic multi_hot(input logic [MAX_COP-1:0] v);
        return (v & (v - MAX_COP'(1))) != '0;
    endfunction

endpackage

// File: rtl/pcpi_prio_enc.sv
// Lowest-index-first priority encoder: returns the index of the lowest set
// request bit and whether any bit was set at all.
module pcpi_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             hit
);

    always_comb begin
        idx = '0;
        hit = |req;
        // Descending scan so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pcpi_hub.sv
// Registered PCPI fan-out/fan-in hub between picorv32 and NUM_COP coprocessors
// with enable mask, owner locking, re-issue suppression and sticky status.
//
// Handshake: the CPU holds pcpi_valid with stable insn/rs1/rs2 until it sees a
// one-cycle pcpi_ready (or traps). A coprocessor claims the instruction with
// cop_wait (multi-cycle) or cop_ready (result this cycle); the hub answers one
// cycle after the owner's cop_ready and withholds cop_valid until pcpi_valid drops.
module pcpi_hub
    import pcpi_hub_pkg::*;
#(
    parameter int NUM_COP = 4,
    parameter int TIMEOUT = 12,
    parameter int CNT_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pcpi_valid,
    input  logic [DATA_W-1:0]         pcpi_insn,
    input  logic [DATA_W-1:0]         pcpi_rs1,
    input  logic [DATA_W-1:0]         pcpi_rs2,
    output logic                      pcpi_wr,
    output logic [DATA_W-1:0]         pcpi_rd,
    output logic                      pcpi_wait,
    output logic                      pcpi_ready,
    output logic [NUM_COP-1:0]        cop_valid,
    output logic [DATA_W-1:0]         cop_insn,
    output logic [DATA_W-1:0]         cop_rs1,
    output logic [DATA_W-1:0]         cop_rs2,
    input  logic [NUM_COP-1:0]        cop_wr,
    input  logic [DATA_W*NUM_COP-1:0] cop_rd,
    input  logic [NUM_COP-1:0]        cop_wait,
    input  logic [NUM_COP-1:0]        cop_ready,
    input  logic [NUM_COP-1:0]        cfg_en,
    output logic [OWNER_W-1:0]        stat_owner,
    output logic                      stat_conflict,
    output logic                      stat_timeout,
    input  logic                      stat_clr,
    output state_t                    dbg_state
);

    localparam logic [NUM_COP-1:0] ONE_HOT0 = NUM_COP'(1);

    state_t               state;
    logic [OWNER_W-1:0]   owner;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_COP-1:0]   en_q;

    logic [NUM_COP-1:0]   en_rdy;
    logic [NUM_COP-1:0]   en_wait;
    logic [NUM_COP-1:0]   owner_mask;
    logic [OWNER_W-1:0]   rdy_idx;
    logic                 rdy_hit;
    logic [OWNER_W-1:0]   wait_idx;
    logic                 wait_hit;
    logic [OWNER_W-1:0]   sel_idx;
    logic [DATA_W-1:0]    sel_rd;
    logic                 sel_wr;
    logic                 owner_rdy;
    logic                 claim_active;
    logic                 timeout_set;
    logic                 conflict_set;

    assign cop_insn  = pcpi_insn;
    assign cop_rs1   = pcpi_rs1;
    assign cop_rs2   = pcpi_rs2;
    assign dbg_state = state;

    assign en_rdy     = cop_ready & cfg_en;
    assign en_wait    = cop_wait & cfg_en;
    assign owner_mask = ONE_HOT0 << owner;
    assign owner_rdy  = |(cop_ready & owner_mask);

    pcpi_prio_enc #(.N(NUM_COP), .IDX_W(OWNER_W)) u_rdy_enc (
        .req (en_rdy),
        .idx (rdy_idx),
        .hit (rdy_hit)
    );

    pcpi_prio_enc #(.N(NUM_COP), .IDX_W(OWNER_W)) u_wait_enc (
        .req (en_wait),
        .idx (wait_idx),
        .hit (wait_hit)
    );

    // In CLAIM the result comes from the ready winner; in BUSY from the owner.
    assign sel_idx = (state == ST_CLAIM) ? rdy_idx : owner;

    always_comb begin
        sel_rd = '0;
        sel_wr = 1'b0;
        for (int i = 0; i < NUM_COP; i++) begin
            if (sel_idx == OWNER_W'(i)) begin
                sel_rd = cop_rd[i*DATA_W +: DATA_W];
                sel_wr = cop_wr[i];
            end
        end
    end

    assign claim_active = (state == ST_CLAIM) && pcpi_valid;
    assign timeout_set  = claim_active && !rdy_hit && !wait_hit
                          && (cnt == CNT_W'(TIMEOUT - 1));
    // Non-owner readys in BUSY are judged against the mask latched at claim time.
    assign conflict_set = (claim_active && multi_hot(MAX_COP'(en_rdy)))
                          || ((state == ST_BUSY) && |(cop_ready & en_q & ~owner_mask));

    always_comb begin
        cop_valid = '0;
        pcpi_wait = 1'b0;
        case (state)
            ST_IDLE: begin
                cop_valid = {NUM_COP{pcpi_valid}} & cfg_en;
            end
            ST_CLAIM: begin
                cop_valid = {NUM_COP{pcpi_valid}} & cfg_en;
                pcpi_wait = |en_wait;
            end
            ST_BUSY: begin
                cop_valid = {NUM_COP{pcpi_valid}} & owner_mask;
                pcpi_wait = 1'b1;
            end
            default: begin
                cop_valid = '0;
                pcpi_wait = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            owner         <= '0;
            cnt           <= '0;
            en_q          <= '0;
            pcpi_wr       <= 1'b0;
            pcpi_rd       <= '0;
            pcpi_ready    <= 1'b0;
            stat_owner    <= '0;
            stat_conflict <= 1'b0;
            stat_timeout  <= 1'b0;
        end else begin
            pcpi_ready <= 1'b0;

            if (conflict_set) begin
                stat_conflict <= 1'b1;
            end else if (stat_clr) begin
                stat_conflict <= 1'b0;
            end

            if (timeout_set) begin
                stat_timeout <= 1'b1;
            end else if (stat_clr) begin
                stat_timeout <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    en_q <= cfg_en;
                    if (pcpi_valid) begin
                        cnt   <= '0;
                        state <= ST_CLAIM;
                    end
                end
                ST_CLAIM: begin
                    en_q <= cfg_en;
                    cnt  <= cnt + CNT_W'(1);
                    if (!pcpi_valid) begin
                        state <= ST_IDLE;
                    end else if (rdy_hit) begin
                        owner      <= rdy_idx;
                        pcpi_wr    <= sel_wr;
                        pcpi_rd    <= sel_rd;
                        pcpi_ready <= 1'b1;
                        stat_owner <= rdy_idx;
                        state      <= ST_RESP;
                    end else if (wait_hit) begin
                        owner <= wait_idx;
                        state <= ST_BUSY;
                    end else if (timeout_set) begin
                        state <= ST_DONE;
                    end
                end
                ST_BUSY: begin
                    // The owner completes even if its enable was dropped meanwhile.
                    if (owner_rdy) begin
                        pcpi_wr    <= sel_wr;
                        pcpi_rd    <= sel_rd;
                        pcpi_ready <= 1'b1;
                        stat_owner <= owner;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    pcpi_wr    <= 1'b0;
                    stat_owner <= owner;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    pcpi_wr <= 1'b0;
                    if (!pcpi_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcpi_hub.sv
// Randomized transaction-level bench for pcpi_hub with a behavioural model of
// claim arbitration, owner completion, timeout and sticky status.
module tb_pcpi_hub;
    import pcpi_hub_pkg::*;

    localparam int NC      = 4;
    localparam int TIMEOUT = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              pcpi_valid;
    logic [31:0]       pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic              pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0]       pcpi_rd;
    logic [NC-1:0]     cop_valid;
    logic [31:0]       cop_insn, cop_rs1, cop_rs2;
    logic [NC-1:0]     cop_wr, cop_wait, cop_ready, cfg_en;
    logic [32*NC-1:0]  cop_rd;
    logic [2:0]        stat_owner;
    logic              stat_conflict, stat_timeout, stat_clr;
    state_t            dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic        exp_conflict, exp_timeout;
    logic [31:0] exp_rd;
    logic [2:0]  exp_owner;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    pcpi_hub #(.NUM_COP(NC), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .cop_valid(cop_valid), .cop_insn(cop_insn), .cop_rs1(cop_rs1), .cop_rs2(cop_rs2),
        .cop_wr(cop_wr), .cop_rd(cop_rd), .cop_wait(cop_wait), .cop_ready(cop_ready),
        .cfg_en(cfg_en), .stat_owner(stat_owner), .stat_conflict(stat_conflict),
        .stat_timeout(stat_timeout), .stat_clr(stat_clr), .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
        cop_wr = '0; cop_rd = '0; cop_wait = '0; cop_ready = '0; cfg_en = 4'hF; stat_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_conflict = 1'b0; exp_timeout = 1'b0; exp_rd = '0; exp_owner = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic check_resp(input int own, input logic wr);
        exp_rd    = exp_q.pop_front();
        exp_owner = 3'(own);
        #1;
        check("resp_ready", pcpi_ready, 1);
        check("resp_wr", pcpi_wr, wr);
        check("resp_rd", pcpi_rd, exp_rd);
        check("resp_owner", stat_owner, exp_owner);
        check("resp_wait", pcpi_wait, 0);
        check("resp_cop_valid", cop_valid, 0);
        check("resp_conflict", stat_conflict, exp_conflict);
        @(negedge clk);
    endtask

    // One instruction: idle cycles in CLAIM, then one cycle presenting wmask/rmask.
    task automatic run_txn(input logic [3:0] en, input int delay, input logic [3:0] wmask,
                           input logic [3:0] rmask, input int busy_n, input bit intrude,
                           input int hold, input logic [31:0] rd_val, input logic wr_val,
                           input bit clr_at_hit);
        logic [3:0] er, ew, omask, others;
        int own;
        bit do_clr;
        er = rmask & en;
        ew = wmask & en;
        cfg_en = en; pcpi_valid = 1'b1;
        pcpi_insn = $urandom; pcpi_rs1 = $urandom; pcpi_rs2 = $urandom;
        #1;
        check("idle_cop_valid", cop_valid, en);
        check("insn_bcast", cop_insn, pcpi_insn);
        check("rs1_bcast", cop_rs1, pcpi_rs1);
        check("rs2_bcast", cop_rs2, pcpi_rs2);
        @(negedge clk);
        for (int i = 0; i < delay; i++) begin
            #1;
            check("claim_state", dbg_state, ST_CLAIM);
            check("claim_cop_valid", cop_valid, en);
            check("claim_wait", pcpi_wait, 0);
            @(negedge clk);
        end
        for (int i = 0; i < NC; i++) cop_rd[i*32 +: 32] = $urandom;
        cop_wr = 4'($urandom);
        own = (er != 0) ? lowest(er) : lowest(ew);
        if (own >= 0) begin
            cop_rd[own*32 +: 32] = rd_val;
            cop_wr[own] = wr_val;
            exp_q.push_back(rd_val);
        end
        cop_ready = rmask; cop_wait = wmask; stat_clr = clr_at_hit;
        if ($countones(er) > 1) exp_conflict = 1'b1;
        else if (clr_at_hit) exp_conflict = 1'b0;
        if (clr_at_hit) exp_timeout = 1'b0;
        #1;
        check("hit_wait", pcpi_wait, |ew);
        check("hit_cop_valid", cop_valid, en);
        check("hit_no_ready", pcpi_ready, 0);
        @(negedge clk);
        stat_clr = 1'b0;
        if (er != 0) begin
            cop_ready = '0; cop_wait = '0;
            check_resp(own, wr_val);
        end else if (ew != 0) begin
            omask  = 4'b0001 << own;
            others = en & ~omask;
            cop_ready = '0; cop_wait = omask;
            for (int i = 0; i < busy_n; i++) begin
                cfg_en = 4'($urandom);
                if (intrude && i == 0 && others != 0) begin
                    cop_ready = others; exp_conflict = 1'b1;
                end else begin
                    cop_ready = '0;
                end
                #1;
                check("busy_state", dbg_state, ST_BUSY);
                check("busy_wait", pcpi_wait, 1);
                check("busy_cop_valid", cop_valid, omask);
                check("busy_no_ready", pcpi_ready, 0);
                @(negedge clk);
            end
            cfg_en = 4'($urandom);
            cop_ready = omask; cop_wait = '0;
            #1;
            check("own_rdy_state", dbg_state, ST_BUSY);
            check("own_rdy_no_ready", pcpi_ready, 0);
            @(negedge clk);
            cop_ready = '0;
            check_resp(own, wr_val);
        end else begin
            for (int i = delay + 1; i < TIMEOUT; i++) begin
                #1;
                check("to_claim_state", dbg_state, ST_CLAIM);
                check("to_cop_valid", cop_valid, en);
                check("to_no_ready", pcpi_ready, 0);
                @(negedge clk);
            end
            exp_timeout = 1'b1;
            cop_ready = '0; cop_wait = '0;
            #1;
            check("to_state", dbg_state, ST_DONE);
            check("to_flag", stat_timeout, 1);
            check("to_no_ready2", pcpi_ready, 0);
            @(negedge clk);
        end
        for (int i = 0; i < hold; i++) begin
            #1;
            check("done_state", dbg_state, ST_DONE);
            check("done_cop_valid", cop_valid, 0);
            check("done_ready", pcpi_ready, 0);
            check("done_wr", pcpi_wr, 0);
            check("done_rd_hold", pcpi_rd, exp_rd);
            @(negedge clk);
        end
        pcpi_valid = 1'b0;
        do_clr = ($urandom_range(0, 3) == 0);
        stat_clr = do_clr;
        #1;
        check("done_last_state", dbg_state, ST_DONE);
        check("done_last_cop_valid", cop_valid, 0);
        @(negedge clk);
        stat_clr = 1'b0;
        if (do_clr) begin
            exp_conflict = 1'b0; exp_timeout = 1'b0;
        end
        #1;
        check("back_idle", dbg_state, ST_IDLE);
        check("sticky_conflict", stat_conflict, exp_conflict);
        check("sticky_timeout", stat_timeout, exp_timeout);
        check("owner_hold", stat_owner, exp_owner);
        check("rd_hold", pcpi_rd, exp_rd);
    endtask

    task automatic reset_mid_op();
        cfg_en = 4'hF; pcpi_valid = 1'b1;
        @(negedge clk);
        cop_wait = 4'b0100;
        @(negedge clk);
        #1;
        check("pre_rst_state", dbg_state, ST_BUSY);
        check("pre_rst_cop_valid", cop_valid, 4'b0100);
        reset = 1'b1; pcpi_valid = 1'b0; cop_wait = '0;
        @(negedge clk);
        reset = 1'b0;
        exp_conflict = 1'b0; exp_timeout = 1'b0; exp_rd = '0; exp_owner = '0;
        #1;
        check("rst_mid_cop_valid", cop_valid, 0);
        check("rst_mid_wait", pcpi_wait, 0);
        check("rst_mid_ready", pcpi_ready, 0);
        check("rst_mid_conflict", stat_conflict, 0);
        check("rst_mid_timeout", stat_timeout, 0);
        check("rst_mid_state", dbg_state, ST_IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] en, wm, rm;
        do_reset();
        #1;
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_ready", pcpi_ready, 0);
        check("rst_wr", pcpi_wr, 0);
        check("rst_wait", pcpi_wait, 0);
        check("rst_rd", pcpi_rd, 0);
        check("rst_owner", stat_owner, 0);
        check("rst_conflict", stat_conflict, 0);
        check("rst_timeout", stat_timeout, 0);
        @(negedge clk);

        run_txn(4'hF, 0, 4'b0000, 4'b0010, 0, 0, 3, 32'h0000_002A, 1'b1, 1'b0);
        run_txn(4'hF, 0, 4'b0100, 4'b0000, 33, 0, 2, 32'hDEAD_BEEF, 1'b1, 1'b0);
        run_txn(4'hF, 1, 4'b0000, 4'b1001, 0, 0, 1, 32'h0000_0001, 1'b1, 1'b1);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        exp_conflict = 1'b0; exp_timeout = 1'b0;
        #1;
        check("clr_conflict", stat_conflict, 0);
        run_txn(4'b1101, 0, 4'b0000, 4'b0010, 0, 0, 2, 32'h0, 1'b0, 1'b0);
        reset_mid_op();
        run_txn(4'hF, 2, 4'b1000, 4'b0000, 3, 1, 1, 32'h1234_5678, 1'b1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            en = 4'($urandom);
            wm = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            rm = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            run_txn(en, $urandom_range(0, 4), wm, rm, $urandom_range(0, 6),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom,
                    1'($urandom_range(0, 1)), 1'b0);
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pcpi_hub.md
Name: pcpi_hub

Overview:
- Parametrised, registered PCPI fan-out/fan-in hub between the picorv32 PCPI port and NUM_COP coprocessors (mul, div, exact/approx mul, future units).
- Replaces the flat OR/priority-mux glue in the cpu wrapper.
- Adds a per-channel enable mask, owner locking and re-issue suppression.
- Adds a registered response, a claim timeout, and sticky conflict/timeout status.

Parameters:
- NUM_COP, 4, number of coprocessor channels (1..8); index 0 has the highest priority.
- TIMEOUT, 12, cycles in CLAIM with no wait/ready before the hub abandons the instruction (must be < 16, the picorv32 PCPI timeout).
- CNT_W, 4, width of the claim timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pcpi_valid  in  1  CPU instruction valid
- pcpi_insn  in  32  CPU instruction word
- pcpi_rs1  in  32  operand 1
- pcpi_rs2  in  32  operand 2
- pcpi_wr  out  1  registered write-back flag to CPU
- pcpi_rd  out  32  registered result to CPU
- pcpi_wait  out  1  wait to CPU
- pcpi_ready  out  1  registered ready pulse to CPU
- cop_valid  out  NUM_COP  per-channel gated valid
- cop_insn / cop_rs1 / cop_rs2  out  32 each  broadcast copies of insn/rs1/rs2
- cop_wr  in  NUM_COP  per-channel wr
- cop_rd  in  32*NUM_COP  per-channel result; channel i occupies bits [32i+31:32i]
- cop_wait  in  NUM_COP  per-channel wait
- cop_ready  in  NUM_COP  per-channel ready
- cfg_en  in  NUM_COP  channel enable mask; disabled channels never see valid and their wait/ready are ignored
- stat_owner  out  3  index of the last channel that completed
- stat_conflict  out  1  sticky: more than one enabled ready in the same cycle
- stat_timeout  out  1  sticky: a claim timed out
- stat_clr  in  1  clears both sticky flags; ignored if a set event occurs in the same cycle (set wins)

Behaviour:
- Reset is synchronous and active-high.
  - State goes to IDLE.
  - pcpi_wr, pcpi_ready, pcpi_wait and stat_conflict/stat_timeout are 0.
  - pcpi_rd, stat_owner and the timeout counter are 0; owner register is 0.
- Reset mid-operation aborts any instruction in flight: cop_valid drops in the cycle after reset is sampled.
- FSM states: IDLE, CLAIM, BUSY, RESP, DONE.
- IDLE
  - pcpi_valid=1 -> CLAIM and clear the counter.
  - cop_valid = pcpi_valid & cfg_en, combinationally, so each coprocessor decodes in the same cycle.
- CLAIM
  - cop_valid = pcpi_valid & cfg_en; the counter increments each cycle.
  - pcpi_wait = OR of enabled cop_wait.
  - Any enabled ready -> latch the lowest-index ready channel as owner, register its wr/rd, go to RESP.
  - Otherwise any enabled wait -> latch the lowest-index waiting channel as owner, go to BUSY.
  - Counter reaches TIMEOUT -> set stat_timeout, go to DONE. No response is given; the CPU traps as an illegal instruction.
  - pcpi_valid drops -> IDLE.
- BUSY
  - cop_valid is asserted only for the owner.
  - pcpi_wait = 1.
  - Owner ready -> register wr/rd, go to RESP.
  - Readys from non-owners are ignored and set stat_conflict.
- RESP
  - pcpi_ready=1 for exactly one cycle; pcpi_wr and pcpi_rd hold the registered values.
  - pcpi_wait=0; all cop_valid=0.
  - stat_owner <= owner; go to DONE.
- DONE
  - All cop_valid=0, which suppresses re-issue to the coprocessor while picorv32 is still holding pcpi_valid.
  - pcpi_ready and pcpi_wr return to 0.
  - pcpi_valid=0 -> IDLE; otherwise stay in DONE.
- Latency: owner cop_ready sampled at cycle t -> pcpi_ready high at t+1.
- Multiple enabled readys in CLAIM: lowest index wins and stat_conflict is set.
- cfg_en changes are sampled only in IDLE/CLAIM. A channel that is disabled while it is the owner still completes.
- pcpi_rd and stat_owner hold their values between instructions.
- cop_insn/cop_rs1/cop_rs2 are pure wires.

Decomposition:
- Package pcpi_hub_pkg holds:
  - the FSM state encoding (3 bits, IDLE=0, CLAIM=1, BUSY=2, RESP=3, DONE=4);
  - the PCPI data width constant (32);
  - the OWNER_W constant (3).
- One sub-module, pcpi_prio_enc: parametrised lowest-index-first priority encoder returning index + any-hit. It is used for both the ready and the wait claims.

Test Plan:
- Single-cycle unit: NUM_COP=4, cfg_en=4'b1111, pcpi_valid, cop_ready[1]=1, cop_wr[1]=1, cop_rd[1]=32'h0000_002A in the first CLAIM cycle -> next cycle pcpi_ready=1, pcpi_wr=1, pcpi_rd=32'h2A, stat_owner=1; cop_valid=0 in DONE until pcpi_valid drops.
- Multi-cycle unit: cop_wait[2] high for 33 cycles, then cop_ready[2] with rd=32'hDEAD_BEEF -> pcpi_wait high throughout, only cop_valid[2] asserted in BUSY, pcpi_ready one cycle after ready, rd=32'hDEADBEEF.
- Conflict: cop_ready[0] and cop_ready[3] in the same cycle, rd0=1, rd3=3 -> pcpi_rd=1, stat_conflict=1; stat_clr pulse -> stat_conflict=0.
- Mask: cfg_en=4'b1101, cop_ready[1] asserted -> ignored, cop_valid[1]=0; no response -> after 12 CLAIM cycles stat_timeout=1, state DONE, pcpi_ready never asserts.
- Reset mid-op: reset asserted in BUSY -> next cycle all cop_valid=0, pcpi_wait=0, pcpi_ready=0, sticky flags 0, a new instruction proceeds normally.
- Back-to-back: two instructions separated by one pcpi_valid-low cycle -> two distinct pcpi_ready pulses; no duplicate cop_valid during either DONE.
